mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter onto one shared memory port with response timeout
//
// Parameters
//   TIMEOUT_CYCLES : memory-response timeout in cycles, 0 disables it (0..65535)
//   M0_PRIORITY    : 1 = requester 0 wins every conflict, 0 = round-robin
//
// Ports
//   clk, rst_n                      : clock, synchronous active-low reset
//   mX_valid_i                      : requester X request, held until mX_ready_o
//   mX_addr_i, mX_wdata_i, mX_we_i  : requester X address, write data, byte enables (0 = read)
//   mX_ready_o                      : one-cycle completion pulse to requester X
//   mX_rdata_o                      : read data, non-zero only with a normal completion
//   mX_err_o                        : timeout flag, qualifies mX_ready_o
//   mem_valid_o                     : request to the shared memory port
//   mem_addr_o, mem_wdata_o, mem_we_o : forwarded request of the granted requester
//   mem_ready_i, mem_rdata_i        : memory completion pulse and read data

module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned M0_PRIORITY    = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_valid_i,
    output logic        m0_ready_o,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_we_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_valid_i,
    output logic        m1_ready_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_we_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_we_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
    localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam bit          FIXED_PRIO  = (M0_PRIORITY != 0);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic        last_gnt1;     // 1 = requester 1 received the most recent grant
    logic [15:0] wait_cnt;      // granted cycles spent without a memory response

    logic        granted;
    logic        sel1;
    logic        timeout_hit;
    logic        mem_done;
    logic        pick1;

    always_comb begin
        // Outputs are gated by rst_n so everything reads 0 while reset is asserted,
        // including a cycle where reset lands in the middle of a transfer.
        granted     = rst_n && ((state == GNT0) || (state == GNT1));
        sel1        = (state == GNT1);
        // A response arriving in the timeout cycle takes precedence over the timeout.
        timeout_hit = granted && TIMEOUT_EN && (wait_cnt == TIMEOUT_VAL) && !mem_ready_i;
        mem_done    = granted && mem_ready_i;

        // Requester 1 wins when it is alone, or on a conflict when round-robin
        // says requester 0 was served last.
        pick1 = m1_valid_i && (!m0_valid_i || (!FIXED_PRIO && !last_gnt1));

        state_next = state;
        case (state)
            IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    state_next = pick1 ? GNT1 : GNT0;
                end
            end
            GNT0, GNT1: begin
                if (mem_done || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        mem_valid_o = granted && !timeout_hit;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = '0;
        if (granted) begin
            mem_addr_o  = sel1 ? m1_addr_i  : m0_addr_i;
            mem_wdata_o = sel1 ? m1_wdata_i : m0_wdata_i;
            mem_we_o    = sel1 ? m1_we_i    : m0_we_i;
        end

        m0_ready_o = granted && !sel1 && (mem_done || timeout_hit);
        m0_err_o   = !sel1 && timeout_hit;
        m0_rdata_o = (!sel1 && mem_done) ? mem_rdata_i : '0;

        m1_ready_o = granted && sel1 && (mem_done || timeout_hit);
        m1_err_o   = sel1 && timeout_hit;
        m1_rdata_o = (sel1 && mem_done) ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_gnt1 <= 1'b1;
            wait_cnt  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                // Holding the counter at 0 throughout IDLE clears it on every grant entry.
                wait_cnt <= '0;
                if (state_next != IDLE) begin
                    last_gnt1 <= (state_next == GNT1);
                end
            end else if (!mem_ready_i && (wait_cnt != 16'hFFFF)) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - checks round-robin and fixed-priority arbiter instances against a transaction model

module tb_mem_port_arbiter;

    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m0_valid, m1_valid, mem_ready;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
    logic [3:0]  m0_we, m1_we;

    logic        mv [2];
    logic        r0 [2];
    logic        e0 [2];
    logic        r1 [2];
    logic        e1 [2];
    logic [31:0] ma [2];
    logic [31:0] mwd [2];
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic [3:0]  mwe [2];

    // Instance 0: round-robin, instance 1: fixed priority; both see identical stimulus.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .TIMEOUT_CYCLES(T),
            .M0_PRIORITY   (g)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .m0_valid_i (m0_valid),
            .m0_ready_o (r0[g]),
            .m0_addr_i  (m0_addr),
            .m0_wdata_i (m0_wdata),
            .m0_we_i    (m0_we),
            .m0_rdata_o (rd0[g]),
            .m0_err_o   (e0[g]),
            .m1_valid_i (m1_valid),
            .m1_ready_o (r1[g]),
            .m1_addr_i  (m1_addr),
            .m1_wdata_i (m1_wdata),
            .m1_we_i    (m1_we),
            .m1_rdata_o (rd1[g]),
            .m1_err_o   (e1[g]),
            .mem_valid_o(mv[g]),
            .mem_ready_i(mem_ready),
            .mem_addr_o (ma[g]),
            .mem_wdata_o(mwd[g]),
            .mem_we_o   (mwe[g]),
            .mem_rdata_i(mem_rdata)
        );
    end

    typedef struct packed {
        logic        mem_valid;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_we;
        logic        m0_ready;
        logic [31:0] m0_rdata;
        logic        m0_err;
        logic        m1_ready;
        logic [31:0] m1_rdata;
        logic        m1_err;
    } out_t;

    typedef struct {
        logic        rst_n;
        logic        m0_v;
        logic        m1_v;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_mv;
        logic        e_r0;
        logic        e_e0;
        logic [31:0] e_rd0;
        logic        e_r1;
        logic        e_e1;
    } row_t;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Transaction-level model: who owns the port, how many cycles the current
    // transfer has lasted (1 = first granted cycle), and who was served last.
    int owner [2];
    int age   [2];
    int last  [2];

    task automatic check(input string name, input int p, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, p, cyc, a, e);
        end
    endtask

    function automatic out_t get_act(input int p);
        out_t o;
        o.mem_valid = mv[p];
        o.mem_addr  = ma[p];
        o.mem_wdata = mwd[p];
        o.mem_we    = mwe[p];
        o.m0_ready  = r0[p];
        o.m0_rdata  = rd0[p];
        o.m0_err    = e0[p];
        o.m1_ready  = r1[p];
        o.m1_rdata  = rd1[p];
        o.m1_err    = e1[p];
        return o;
    endfunction

    function automatic out_t model_out(input int p);
        out_t o;
        bit   expire;
        o = '0;
        if (rst_n && owner[p] >= 0) begin
            // The transfer gives up on its (T+1)-th granted cycle if memory is still silent.
            expire      = (T > 0) && (age[p] == T + 1) && !mem_ready;
            o.mem_valid = !expire;
            o.mem_addr  = (owner[p] == 1) ? m1_addr  : m0_addr;
            o.mem_wdata = (owner[p] == 1) ? m1_wdata : m0_wdata;
            o.mem_we    = (owner[p] == 1) ? m1_we    : m0_we;
            if (owner[p] == 0) begin
                o.m0_ready = mem_ready || expire;
                o.m0_err   = expire;
                o.m0_rdata = mem_ready ? mem_rdata : 32'h0;
            end else begin
                o.m1_ready = mem_ready || expire;
                o.m1_err   = expire;
                o.m1_rdata = mem_ready ? mem_rdata : 32'h0;
            end
        end
        return o;
    endfunction

    task automatic model_step();
        for (int p = 0; p < 2; p++) begin
            int w;
            if (!rst_n) begin
                owner[p] = -1;
                age[p]   = 0;
                last[p]  = 1;
            end else if (owner[p] < 0) begin
                if (m0_valid || m1_valid) begin
                    if (m0_valid && m1_valid) w = (p == 1) ? 0 : 1 - last[p];
                    else                      w = m1_valid ? 1 : 0;
                    owner[p] = w;
                    last[p]  = w;
                    age[p]   = 1;
                end
            end else if (mem_ready || (T > 0 && age[p] == T + 1)) begin
                owner[p] = -1;
            end else begin
                age[p]++;
            end
        end
    endtask

    task automatic check_out(input int p);
        out_t a, e;
        a = get_act(p);
        e = model_out(p);
        check("mem_valid", p, 32'(a.mem_valid), 32'(e.mem_valid));
        check("mem_addr",  p, a.mem_addr,        e.mem_addr);
        check("mem_wdata", p, a.mem_wdata,       e.mem_wdata);
        check("mem_we",    p, 32'(a.mem_we),     32'(e.mem_we));
        check("m0_ready",  p, 32'(a.m0_ready),   32'(e.m0_ready));
        check("m0_rdata",  p, a.m0_rdata,        e.m0_rdata);
        check("m0_err",    p, 32'(a.m0_err),     32'(e.m0_err));
        check("m1_ready",  p, 32'(a.m1_ready),   32'(e.m1_ready));
        check("m1_rdata",  p, a.m1_rdata,        e.m1_rdata);
        check("m1_err",    p, 32'(a.m1_err),     32'(e.m1_err));
    endtask

    task automatic sample();
        @(negedge clk);
        check_out(0);
        check_out(1);
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    row_t tbl [21];

    initial begin
        rst_n = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; mem_ready = 1'b0;
        m0_addr = 32'h100; m0_wdata = 32'h0; m0_we = 4'h0;
        m1_addr = 32'h200; m1_wdata = 32'h55AA55AA; m1_we = 4'hF;
        mem_rdata = 32'h0;
        @(posedge clk);
        model_step();
        #1;

        //            rst  m0   m1   rdy  rdata          mv   r0   e0   rd0            r1   e1
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b1,1'b1,32'hAAAA5555, 1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0};
        // single m0 read, memory answers on the third granted cycle
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b1,32'hDEADBEEF, 1'b1,1'b1,1'b0,32'hDEADBEEF, 1'b0,1'b0};
        // memory ready while idle is ignored
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,32'hCAFEF00D, 1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0};
        // m1 write with silent memory times out on the fifth granted cycle
        tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0};
        for (int i = 8; i <= 11; i++)
            tbl[i] = '{1'b1,1'b0,1'b1,1'b0,32'h0,     1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0};
        tbl[12] = '{1'b1,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b1,1'b1};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0};
        // response on the fifth granted cycle beats the timeout
        tbl[14] = '{1'b1,1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0};
        for (int i = 15; i <= 18; i++)
            tbl[i] = '{1'b1,1'b1,1'b0,1'b0,32'h0,     1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0};
        tbl[19] = '{1'b1,1'b1,1'b0,1'b1,32'h12345678, 1'b1,1'b1,1'b0,32'h12345678, 1'b0,1'b0};
        tbl[20] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0};

        for (int i = 0; i < 21; i++) begin
            rst_n = tbl[i].rst_n; m0_valid = tbl[i].m0_v; m1_valid = tbl[i].m1_v;
            mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rdata;
            sample();
            check("tbl_mem_valid", 0, 32'(mv[0]), 32'(tbl[i].e_mv));
            check("tbl_m0_ready",  0, 32'(r0[0]), 32'(tbl[i].e_r0));
            check("tbl_m0_err",    0, 32'(e0[0]), 32'(tbl[i].e_e0));
            check("tbl_m0_rdata",  0, rd0[0],     tbl[i].e_rd0);
            check("tbl_m1_ready",  0, 32'(r1[0]), 32'(tbl[i].e_r1));
            check("tbl_m1_err",    0, 32'(e1[0]), 32'(tbl[i].e_e1));
            check("tbl_m1_rdata",  0, rd1[0],     32'h0);
            advance();
        end

        // Both requesters always valid, one-cycle memory: round-robin alternates
        // starting with m0, fixed priority serves m0 every time.
        rst_n = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; mem_ready = 1'b0;
        sample(); advance();
        rst_n = 1'b1; m0_valid = 1'b1; m1_valid = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mem_rdata = $urandom;
            sample();
            if (k % 2 == 0) begin
                check("conf_idle_mv", 0, 32'(mv[0]), 32'h0);
            end else begin
                check("rr_m0_ready", 0, 32'(r0[0]), 32'(((k / 2) % 2) == 0));
                check("rr_m1_ready", 0, 32'(r1[0]), 32'(((k / 2) % 2) == 1));
                check("fp_m0_ready", 1, 32'(r0[1]), 32'h1);
                check("fp_m1_ready", 1, 32'(r1[1]), 32'h0);
            end
            advance();
        end

        // Reset while m0 waits on memory: no completion, idle afterwards, then a clean transfer.
        rst_n = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; mem_ready = 1'b0;
        sample(); advance();
        rst_n = 1'b1; m0_valid = 1'b1;
        sample(); advance();
        sample(); advance();
        rst_n = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hBAD0BAD0;
        sample();
        check("rst_m0_ready", 0, 32'(r0[0]), 32'h0);
        advance();
        rst_n = 1'b1; mem_ready = 1'b0;
        sample();
        check("rst_after_mv", 0, 32'(mv[0]), 32'h0);
        advance();
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        sample();
        check("rst_resume_rdy", 0, 32'(r0[0]), 32'h1);
        check("rst_resume_rd",  0, rd0[0], 32'h0BADF00D);
        advance();
        m0_valid = 1'b0; mem_ready = 1'b0;

        // Random traffic, including requesters that drop valid mid-transfer and sporadic resets.
        for (int n = 0; n < 2000; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            m0_valid  = ($urandom_range(0, 2) != 0);
            m1_valid  = ($urandom_range(0, 2) != 0);
            mem_ready = ($urandom_range(0, 3) == 0);
            m0_addr   = $urandom; m0_wdata = $urandom; m0_we = 4'($urandom);
            m1_addr   = $urandom; m1_wdata = $urandom; m1_we = 4'($urandom);
            mem_rdata = $urandom;
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
